// File: rtl/weight_bias_loader.sv
// Streams weights then a bias per neuron from a valid/ready source to the neuron array.
// Optional macro LOADER_MULTI_NEURON_EN loads neuron_cnt_in consecutive neurons per start.
module weight_bias_loader #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          layer_num_in,
  input  logic [31:0]          neuron_num_in,
  input  logic [CNT_WIDTH-1:0] num_weight_in,
  input  logic [CNT_WIDTH-1:0] neuron_cnt_in,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 weight_valid,
  output logic [31:0]          weight_value,
  output logic                 bias_valid,
  output logic [31:0]          bias_value,
  output logic [31:0]          config_layer_num,
  output logic [31:0]          config_neuron_num,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, WEIGHT, BIAS} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] nw_q;
  logic [CNT_WIDTH-1:0] wcnt_q;
  logic [CNT_WIDTH-1:0] wcnt_inc;
  logic                 hs;

  assign s_ready  = (state_q == WEIGHT) || (state_q == BIAS);
  assign busy     = (state_q != IDLE);
  assign hs       = s_valid & s_ready;
  assign wcnt_inc = wcnt_q + CNT_WIDTH'(1);

`ifdef LOADER_MULTI_NEURON_EN
  logic [CNT_WIDTH-1:0] ncnt_q;
  logic [CNT_WIDTH-1:0] ntot_q;
  logic [CNT_WIDTH-1:0] ncnt_inc;
  logic                 adv_q;

  assign ncnt_inc = ncnt_q + CNT_WIDTH'(1);
`else
  logic unused_neuron_cnt;
  assign unused_neuron_cnt = ^neuron_cnt_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      nw_q              <= '0;
      wcnt_q            <= '0;
      weight_valid      <= 1'b0;
      weight_value      <= '0;
      bias_valid        <= 1'b0;
      bias_value        <= '0;
      done              <= 1'b0;
      config_layer_num  <= '1;
      config_neuron_num <= '1;
`ifdef LOADER_MULTI_NEURON_EN
      ncnt_q            <= '0;
      ntot_q            <= '0;
      adv_q             <= 1'b0;
`endif
    end else begin
      weight_valid <= 1'b0;
      bias_valid   <= 1'b0;
      done         <= 1'b0;
`ifdef LOADER_MULTI_NEURON_EN
      // Neuron select advances only after the previous bias_valid cycle has been seen.
      adv_q <= 1'b0;
      if (adv_q) begin
        config_neuron_num <= config_neuron_num + 32'd1;
      end
`endif
      unique case (state_q)
        IDLE: begin
          if (start) begin
            config_layer_num  <= layer_num_in;
            config_neuron_num <= neuron_num_in;
            nw_q              <= num_weight_in;
            wcnt_q            <= '0;
`ifdef LOADER_MULTI_NEURON_EN
            ncnt_q            <= '0;
            ntot_q            <= (neuron_cnt_in == '0) ? CNT_WIDTH'(1) : neuron_cnt_in;
`endif
            state_q           <= (num_weight_in != '0) ? WEIGHT : BIAS;
          end else begin
            config_layer_num  <= '1;
            config_neuron_num <= '1;
          end
        end
        WEIGHT: begin
          if (hs) begin
            weight_value <= s_data;
            weight_valid <= 1'b1;
            if (wcnt_inc == nw_q) begin
              wcnt_q  <= '0;
              state_q <= BIAS;
            end else begin
              wcnt_q  <= wcnt_inc;
            end
          end
        end
        BIAS: begin
          if (hs) begin
            bias_value <= s_data;
            bias_valid <= 1'b1;
`ifdef LOADER_MULTI_NEURON_EN
            if (ncnt_inc < ntot_q) begin
              ncnt_q  <= ncnt_inc;
              adv_q   <= 1'b1;
              state_q <= (nw_q != '0) ? WEIGHT : BIAS;
            end else begin
              ncnt_q  <= '0;
              done    <= 1'b1;
              state_q <= IDLE;
            end
`else
            done    <= 1'b1;
            state_q <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bias_loader.sv
// Table-driven scoreboard bench for weight_bias_loader (default or LOADER_MULTI_NEURON_EN build).
module tb_weight_bias_loader;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   layer_num_in, neuron_num_in, s_data;
  logic [CW-1:0] num_weight_in, neuron_cnt_in;
  logic          s_valid, s_ready;
  logic          weight_valid, bias_valid, busy, done;
  logic [31:0]   weight_value, bias_value, config_layer_num, config_neuron_num;

  weight_bias_loader #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .layer_num_in(layer_num_in), .neuron_num_in(neuron_num_in),
    .num_weight_in(num_weight_in), .neuron_cnt_in(neuron_cnt_in),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   layer;
    logic [31:0]   neuron;
    logic [CW-1:0] nw;
    logic [CW-1:0] ncnt;
    bit            stall;
    bit            poke;
    logic [31:0]   base;
    logic [31:0]   bias;
  } vec_t;

  typedef struct {
    bit          is_bias;
    logic [31:0] val;
    logic [31:0] layer;
    logic [31:0] neuron;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every output strobe must match the oldest handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (weight_valid || bias_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, weight_valid, bias_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind", {30'd0, weight_valid, bias_valid}, e.is_bias ? 32'd1 : 32'd2);
          chk(e.is_bias ? "bias_value" : "weight_value",
              e.is_bias ? bias_value : weight_value, e.val);
          chk("cfg_layer", config_layer_num, e.layer);
          chk("cfg_neuron", config_neuron_num, e.neuron);
          chk("done_with_bias", {31'd0, done}, {31'd0, e.is_bias && e.last});
        end
      end else if (done) begin
        chk("done_without_bias", 32'd1, 32'd0);
      end
    end
  end

  task automatic check_idle_reset_state(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_wv"}, {31'd0, weight_valid}, 32'd0);
    chk({tag, "_bv"}, {31'd0, bias_valid}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cfg_layer"}, config_layer_num, 32'hFFFF_FFFF);
    chk({tag, "_cfg_neuron"}, config_neuron_num, 32'hFFFF_FFFF);
  endtask

  task automatic apply_start(input vec_t v);
    @(negedge clk);
    start         = 1'b1;
    layer_num_in  = v.layer;
    neuron_num_in = v.neuron;
    num_weight_in = v.nw;
    neuron_cnt_in = v.ncnt;
    @(negedge clk);
    start         = 1'b0;
    layer_num_in  = 32'hDEAD_BEEF;
    neuron_num_in = 32'h0BAD_F00D;
    num_weight_in = CW'(9);
    neuron_cnt_in = CW'(7);
  endtask

  // Feeds one word per word slot, pushing the expectation at the handshake.
  task automatic feed_word(input vec_t v, input int unsigned n, input bit is_bias,
                           input logic [31:0] data, input bit last, input bit poke_now,
                           inout int unsigned cyc);
    bit got = 1'b0;
    int unsigned tries = 0;
    while (!got && tries < 40) begin
      s_valid = v.stall ? (cyc % 3 == 0) : 1'b1;
      s_data  = s_valid ? data : (32'hBAD0_0000 ^ cyc);
      if (poke_now && tries == 0) begin
        start         = 1'b1;
        layer_num_in  = 32'd9;
        neuron_num_in = 32'd5;
        num_weight_in = CW'(7);
      end
      #1;
      if (s_valid && s_ready) begin
        exp_q.push_back('{is_bias, data, v.layer, v.neuron + n, last});
        got = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      tries++;
    end
    s_valid = 1'b0;
    if (!got) chk("handshake_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_load(input vec_t v);
    int unsigned nn = 1;
    int unsigned cyc = 0;
    int unsigned d0;
`ifdef LOADER_MULTI_NEURON_EN
    nn = (v.ncnt == '0) ? 1 : int'(v.ncnt);
`endif
    d0 = done_cnt;
    apply_start(v);
    for (int unsigned n = 0; n < nn; n++) begin
      for (int unsigned w = 0; w < int'(v.nw); w++)
        feed_word(v, n, 1'b0, v.base * (w + 1) + (n << 8), 1'b0,
                  v.poke && n == 0 && w == 1, cyc);
      feed_word(v, n, 1'b1, v.bias + n, n == nn - 1, 1'b0, cyc);
    end
    @(negedge clk);
    chk("done_count", done_cnt - d0, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
    check_idle_reset_state("after_done");
    repeat (2) @(negedge clk);
    chk("no_restart_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    layer_num_in = '0; neuron_num_in = '0; num_weight_in = '0; neuron_cnt_in = '0;

    vecs.push_back('{32'd2,      32'd17,          CW'(3), CW'(1), 1'b0, 1'b0, 32'h11,   32'hFD8E});
    vecs.push_back('{32'd2,      32'd17,          CW'(3), CW'(1), 1'b1, 1'b0, 32'h11,   32'hFD8E});
    vecs.push_back('{32'd4,      32'd8,           CW'(0), CW'(1), 1'b0, 1'b0, 32'h0,    32'h5});
    vecs.push_back('{32'd2,      32'd17,          CW'(3), CW'(1), 1'b0, 1'b1, 32'h101,  32'h77});
    vecs.push_back('{32'h1234,   32'h40,          CW'(1), CW'(3), 1'b1, 1'b0, 32'hA5A5, 32'hCAFE_BABE});
    vecs.push_back('{32'd6,      32'd30,          CW'(0), CW'(0), 1'b1, 1'b0, 32'h0,    32'h9});
`ifdef LOADER_MULTI_NEURON_EN
    vecs.push_back('{32'd3,      32'd17,          CW'(2), CW'(2), 1'b0, 1'b0, 32'h21,   32'h300});
    vecs.push_back('{32'd3,      32'd17,          CW'(2), CW'(2), 1'b1, 1'b0, 32'h21,   32'h300});
`endif

    repeat (3) @(negedge clk);
    check_idle_reset_state("reset");
    chk("reset_wvalue", weight_value, 32'd0);
    chk("reset_bvalue", bias_value, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_load(vecs[i]);

    // Reset after two of three weights: load abandoned, then a fresh load succeeds.
    begin
      vec_t v;
      int unsigned cyc = 0;
      int unsigned d0;
      v  = '{32'd2, 32'd17, CW'(3), CW'(1), 1'b0, 1'b0, 32'h11, 32'hFD8E};
      d0 = done_cnt;
      apply_start(v);
      feed_word(v, 0, 1'b0, 32'h11, 1'b0, 1'b0, cyc);
      feed_word(v, 0, 1'b0, 32'h22, 1'b0, 1'b0, cyc);
      @(negedge clk);
      chk("midrst_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_idle_reset_state("midrst");
      chk("midrst_wvalue", weight_value, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 32'd0);
      chk("midrst_queue", exp_q.size(), 32'd0);
      run_load(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weight_bias_loader.md
WEIGHT_BIAS_LOADER -- requirements
Module: weight_bias_loader

Interface
- REQ-001: Parameter CNT_WIDTH, default 16, is the width of the weight-count and neuron-count inputs.
- REQ-002: clk  input  1  clock; all logic is on the rising edge.
- REQ-003: rst  input  1  reset; synchronous, active-high.
- REQ-004: start  input  1  one-cycle load request; sampled only in IDLE.
- REQ-005: layer_num_in  input  32  target layer number, captured on start.
- REQ-006: neuron_num_in  input  32  first target neuron number, captured on start.
- REQ-007: num_weight_in  input  CNT_WIDTH  weights per neuron, captured on start.
- REQ-008: neuron_cnt_in  input  CNT_WIDTH  number of consecutive neurons to load, captured on start.
- REQ-009: s_data  input  32  source word (weight or bias).
- REQ-010: s_valid  input  1  s_data is valid.
- REQ-011: s_ready  output  1  loader accepts s_data; a handshake occurs on s_valid & s_ready.
- REQ-012: weight_valid / weight_value  output  1 / 32  registered weight strobe and word for the neurons.
- REQ-013: bias_valid / bias_value  output  1 / 32  registered bias strobe and word.
- REQ-014: config_layer_num / config_neuron_num  output  32 / 32  target select broadcast to all neurons.
- REQ-015: busy  output  1  high in any state other than IDLE.
- REQ-016: done  output  1  one-cycle pulse when the whole load is complete.

Function
- REQ-017: States: IDLE, WEIGHT, BIAS. In IDLE, start=1 captures all *_in inputs and sets config_layer_num=layer_num_in and config_neuron_num=neuron_num_in.
  - Next state is WEIGHT if num_weight_in!=0, otherwise BIAS.
- REQ-018: s_ready = 1 only in WEIGHT and BIAS (combinational from state); s_ready = 0 in IDLE.
- REQ-019: In WEIGHT, each handshake registers s_data to weight_value and asserts weight_valid for exactly the next cycle (latency 1).
  - weight_valid = 0 in any cycle not preceded by a weight handshake.
- REQ-020: A weight counter increments per weight handshake. On the handshake that makes the count equal num_weight, the counter clears and the state goes to BIAS.
- REQ-021: In BIAS, one handshake registers s_data to bias_value and asserts bias_valid for the next cycle; the state then leaves BIAS per REQ-022/REQ-030.
- REQ-022: After the bias handshake of the last neuron, the state returns to IDLE. done is asserted in the same cycle as that final bias_valid.
- REQ-023: config_layer_num and config_neuron_num are held stable from start through the final bias_valid cycle, including during s_valid=0 stalls.
- REQ-024: start while busy=1 is ignored; captured values are not disturbed.
- REQ-025: Word order on s_data per neuron: num_weight weights, then one bias. The loader performs no data modification.
- REQ-026: Counters are CNT_WIDTH wide. The counter wrap point is num_weight; the counter never exceeds num_weight-1 before clearing.

Reset
- REQ-027: rst in any state (including mid-load) forces IDLE and clears the weight counter and neuron counter.
  - weight_valid, bias_valid, done, busy, s_ready = 0; weight_value, bias_value = 0.
- REQ-028: Reset drives config_layer_num and config_neuron_num to 32'hFFFF_FFFF so that no neuron matches.
  - After a completed load they return to 32'hFFFF_FFFF in the cycle after done.
- REQ-029: Any partial load interrupted by rst is abandoned; no done pulse is produced.

Configuration
- REQ-030: Macro LOADER_MULTI_NEURON_EN.
  - Defined: after each bias handshake, if the neuron counter+1 < neuron_cnt (neuron_cnt_in of 0 treated as 1), the neuron counter increments, config_neuron_num increments by 1 on the cycle after bias_valid, and the state returns to WEIGHT (or BIAS if num_weight=0). done fires only after the last neuron.
  - Not defined: neuron_cnt_in is ignored, exactly one neuron is loaded per start, and no neuron counter is built.

Verification
- REQ-031: Load of one neuron.
  - Stimulus: start with layer=2, neuron=17, num_weight=3; stream 0x11, 0x22, 0x33, then bias 0xFD8E.
  - Required response: three weight_valid pulses carrying 0x11, 0x22, 0x33 with config 2/17 stable; bias_valid with 0xFD8E and done in the same cycle; busy=0 on the next cycle.
- REQ-032: Source stalls.
  - Stimulus: same load with s_valid toggling 1,0,0,1,...
  - Required response: weight_valid appears only one cycle after each handshake; config is stable throughout; total of 3 weights and 1 bias.
- REQ-033: Zero weights.
  - Stimulus: num_weight=0 and one word 0x5.
  - Required response: no weight_valid; bias_valid with 0x5 and done.
- REQ-034: Reset mid-operation.
  - Stimulus: rst after 2 of 3 weights.
  - Required response: next cycle state is IDLE, config=0xFFFFFFFF, no done; a new start completes normally.
- REQ-035: start while busy.
  - Stimulus: start pulsed with neuron=5 during a load to neuron=17.
  - Required response: config_neuron_num stays 17 and exactly one done is produced.
- REQ-036: With LOADER_MULTI_NEURON_EN defined.
  - Stimulus: neuron=17, neuron_cnt=2, num_weight=2.
  - Required response: weights and bias go to 17, then to 18; one done, after the bias of neuron 18.
